// File: rtl/ks_sliced_subtractor.sv
// ks_sliced_subtractor: 16-bit subtractor a - b - bin computed as a + ~b + ~bin,
// one 4-bit Kogge-Stone slice per clock, LSB slice first. The carry between
// slices is held in a register, so the critical path is a single 4-bit prefix
// network. Status flags are published only when the last slice completes.
module ks_sliced_subtractor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] diff,
   output logic        bout,
   output logic        ovf,
   output logic        zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic        c_q, c_d;
   logic [15:0] res_q, res_d;
   logic [15:0] diff_q, diff_d;
   logic        bout_q, bout_d;
   logic        ovf_q, ovf_d;
   logic        zero_q, zero_d;

   logic [3:0]  x_s, y_s;
   logic [4:0]  slice_s;
   logic [15:0] res_merge_s;

   // 4-bit Kogge-Stone adder: two prefix levels, returns {carry_out, sum}.
   function automatic logic [4:0] ks_add4(input logic [3:0] x, input logic [3:0] y,
                                          input logic cin);
      logic [3:0] p, g, p1, g1, p2, g2, c;
      p  = x ^ y;
      g  = x & y;
      // level 1: span 2
      p1[0] = p[0];
      g1[0] = g[0];
      for (int i = 1; i < 4; i++) begin
         g1[i] = g[i] | (p[i] & g[i-1]);
         p1[i] = p[i] & p[i-1];
      end
      // level 2: span 4
      p2[1:0] = p1[1:0];
      g2[1:0] = g1[1:0];
      for (int i = 2; i < 4; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
         p2[i] = p1[i] & p1[i-2];
      end
      // carries into each bit from the group terms and the slice carry-in
      c[0] = cin;
      for (int i = 1; i < 4; i++) begin
         c[i] = g2[i-1] | (p2[i-1] & cin);
      end
      return {g2[3] | (p2[3] & cin), p ^ c};
   endfunction

   // Select the operand nibbles for the slice currently being computed.
   always_comb begin
      x_s = 4'h0;
      y_s = 4'h0;
      case (idx_q)
         2'd0:    begin x_s = a_q[3:0];   y_s = ~b_q[3:0];   end
         2'd1:    begin x_s = a_q[7:4];   y_s = ~b_q[7:4];   end
         2'd2:    begin x_s = a_q[11:8];  y_s = ~b_q[11:8];  end
         2'd3:    begin x_s = a_q[15:12]; y_s = ~b_q[15:12]; end
         default: begin x_s = 4'h0;       y_s = 4'h0;        end
      endcase
   end

   assign slice_s = ks_add4(x_s, y_s, c_q);

   // Merge the freshly computed slice into the partial result.
   always_comb begin
      res_merge_s = res_q;
      case (idx_q)
         2'd0:    res_merge_s[3:0]   = slice_s[3:0];
         2'd1:    res_merge_s[7:4]   = slice_s[3:0];
         2'd2:    res_merge_s[11:8]  = slice_s[3:0];
         2'd3:    res_merge_s[15:12] = slice_s[3:0];
         default: res_merge_s        = res_q;
      endcase
   end

   // Next-state logic: accept, step through slices, publish results on the last one.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               c_d     = ~bin;
               idx_d   = 2'd0;
               res_d   = 16'h0000;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            res_d = res_merge_s;
            c_d   = slice_s[4];
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = DONE;
               diff_d  = res_merge_s;
               bout_d  = ~slice_s[4];
               ovf_d   = (a_q[15] != b_q[15]) && (res_merge_s[15] != a_q[15]);
               zero_d  = (res_merge_s == 16'h0000);
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         c_q     <= 1'b0;
         res_q   <= 16'h0000;
         diff_q  <= 16'h0000;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == BUSY);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_ks_sliced_subtractor.sv
// Self-checking bench for ks_sliced_subtractor: expected results are queued at
// acceptance and compared against the outputs when done pulses.
module tb_ks_sliced_subtractor;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        bout;
   logic        ovf;
   logic        zero;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   // {diff, bout, ovf, zero}
   logic [18:0] exp_q[$];
   logic [18:0] last_e = 19'h0;

   ks_sliced_subtractor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain 17-bit subtraction.
   task automatic push_exp(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      logic [16:0] full;
      logic [15:0] d;
      logic        o;
      full = {1'b0, av} - {1'b0, bv} - {16'h0000, bi};
      d    = full[15:0];
      o    = (av[15] != bv[15]) && (d[15] != av[15]);
      exp_q.push_back({d, full[16], o, (d == 16'h0000)});
   endtask

   task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      a     = av;
      b     = bv;
      bin   = bi;
      start = 1'b1;
      push_exp(av, bv, bi);
   endtask

   // Called on a negedge with the DUT idle; checks busy/done timing and hold.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi);
      int d0;
      d0 = done_cnt;
      start_op(av, bv, bi);
      @(negedge clk);
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      bin   = 1'($urandom);
      chk({tag, "_busy0"}, {31'h0, busy}, 32'h1);
      chk({tag, "_nodone0"}, {31'h0, done}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
      end
      @(negedge clk);
      chk({tag, "_done"}, {31'h0, done}, 32'h1);
      chk({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, {31'h0, done}, 32'h0);
      chk({tag, "_hold"}, {13'h0, diff, bout, ovf, zero}, {13'h0, last_e});
      chk({tag, "_done_cnt"}, done_cnt, d0 + 1);
   endtask

   // Scoreboard: compare outputs whenever done is observed.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'h1, 32'h0);
         end else begin
            last_e = exp_q.pop_front();
            chk("diff", {16'h0, diff}, {16'h0, last_e[18:3]});
            chk("bout", {31'h0, bout}, {31'h0, last_e[2]});
            chk("ovf",  {31'h0, ovf},  {31'h0, last_e[1]});
            chk("zero", {31'h0, zero}, {31'h0, last_e[0]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = 16'h0000;
      b     = 16'h0000;
      bin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", {26'h0, busy, done, diff == 16'h0, bout, ovf, zero}, 32'h8);

      // release reset and start on the very first edge
      rst_n = 1'b1;
      run_op("s1234", 16'h1234, 16'h0234, 1'b0);
      run_op("s1000", 16'h1000, 16'h0001, 1'b0);
      run_op("s0000", 16'h0000, 16'h0001, 1'b0);
      run_op("s8000", 16'h8000, 16'h0001, 1'b0);
      run_op("s7fff", 16'h7FFF, 16'hFFFF, 1'b0);
      run_op("s0005", 16'h0005, 16'h0004, 1'b1);
      run_op("sffff", 16'hFFFF, 16'hFFFF, 1'b1);

      // start during busy is ignored; start held in done cycle is accepted
      d0 = done_cnt;
      start_op(16'h0003, 16'h0001, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("bb_busy0", {31'h0, busy}, 32'h1);
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("bb_busy_ign", {31'h0, busy}, 32'h1);
      start_op(16'h0009, 16'h0003, 1'b0);
      @(negedge clk);
      chk("bb_busy3", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("bb_done1", {31'h0, done}, 32'h1);
      @(negedge clk);
      start = 1'b0;
      a = 16'h5555; b = 16'h1111;
      chk("bb_back2back", {30'h0, busy, done}, 32'h2);
      repeat (3) begin
         @(negedge clk);
         chk("bb_busy2", {30'h0, busy, done}, 32'h2);
      end
      @(negedge clk);
      chk("bb_done2", {31'h0, done}, 32'h1);
      @(negedge clk);
      chk("bb_done_cnt", done_cnt, d0 + 2);
      chk("bb_hold", {16'h0, diff}, 32'h6);

      // reset mid-operation aborts it
      d0 = done_cnt;
      start_op(16'h00FF, 16'h0011, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("abort_clear", {26'h0, busy, done, diff == 16'h0, bout, ovf, zero}, 32'h8);
      repeat (6) @(negedge clk);
      chk("abort_no_done", done_cnt, d0);
      chk("abort_outs", {12'h0, busy, done, diff, bout, ovf, zero}, 32'h0);
      rst_n = 1'b1;
      run_op("after_rst", 16'hA5A5, 16'h5A5A, 1'b1);

      chk("queue_empty", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
